// File: rtl/xbar_sched_pkg.sv
// Shared helpers for the crossbar priority scheduler.
// Widths are derived per instance from parameters, so only pure functions live here.
package xbar_sched_pkg;

    // Returns idx+1, wrapping to 0 when idx is the last of n slots (n need not be a power of 2).
    function automatic logic [31:0] wrap_inc(input logic [31:0] idx, input logic [31:0] n);
        return (idx == n - 32'd1) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Cyclic first-set-bit finder: lowest candidate at or after ptr, wrapping at NumIn.
// Bits below ptr are masked in the lower copy of a doubled vector so a plain lowest-one scan wraps.
module rr_prio_pick #(
    parameter int unsigned NumIn = 4
) (
    input  logic [NumIn-1:0]         cand,
    input  logic [$clog2(NumIn)-1:0] ptr,
    output logic                     valid_c,
    output logic [$clog2(NumIn)-1:0] idx_c
);

    localparam int unsigned IdxW = $clog2(NumIn);
    localparam int unsigned PosW = $clog2(2 * NumIn);

    logic [NumIn-1:0]   lower;
    logic [2*NumIn-1:0] dbl;
    logic [PosW-1:0]    pos;

    always_comb begin
        lower   = cand & ~((NumIn'(1) << ptr) - NumIn'(1));
        dbl     = {cand, lower};
        valid_c = 1'b0;
        pos     = '0;
        // Scanning downward leaves the lowest set position in pos.
        for (int i = int'(2 * NumIn) - 1; i >= 0; i--) begin
            if (dbl[i]) begin
                valid_c = 1'b1;
                pos     = PosW'(i);
            end
        end
        idx_c = (pos >= PosW'(NumIn)) ? IdxW'(pos - PosW'(NumIn)) : IdxW'(pos);
    end

endmodule

// File: rtl/xbar_prio_scheduler.sv
// Round-robin priority driver for a crossbar with external priority inputs.
// Initiators that wait StarveThresh cycles are boosted to the front at their addressed target.
module xbar_prio_scheduler
    import xbar_sched_pkg::*;
#(
    parameter int unsigned NumIn        = 4,
    parameter int unsigned NumOut       = 4,
    parameter int unsigned StarveThresh = 15
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [NumIn-1:0]                        req_i,
    input  logic [NumIn-1:0]                        gnt_i,
    input  logic [NumIn-1:0][$clog2(NumOut)-1:0]    add_i,
    input  logic [NumOut-1:0]                       tgt_req_i,
    input  logic [NumOut-1:0]                       tgt_gnt_i,
    input  logic [NumOut-1:0][$clog2(NumIn)-1:0]    tgt_idx_i,
    output logic [NumOut-1:0][$clog2(NumIn)-1:0]    rr_o,
    output logic [NumOut-1:0]                       boost_o,
    output logic [NumIn-1:0]                        starve_o
);

    localparam int unsigned IdxW = $clog2(NumIn);
    localparam int unsigned AddW = $clog2(NumOut);
    localparam int unsigned AgeW = (StarveThresh == 0) ? 1 : $clog2(StarveThresh + 1);

    if (NumIn < 2 || NumOut < 2) begin : g_param_check
        $fatal(1, "xbar_prio_scheduler: NumIn and NumOut must both be >= 2");
    end

    logic [NumOut-1:0][IdxW-1:0]  ptr_q;
    logic [NumIn-1:0][AgeW-1:0]   age_q;
    logic [NumOut-1:0][NumIn-1:0] cand_c;
    logic [NumOut-1:0][IdxW-1:0]  pick_idx;
    logic [NumOut-1:0]            pick_valid;

    // Pointers advance past the winner of each target handshake; ages track unserved waiting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            age_q <= '0;
        end else begin
            for (int k = 0; k < int'(NumOut); k++) begin
                if (tgt_req_i[k] && tgt_gnt_i[k]) begin
                    ptr_q[k] <= IdxW'(wrap_inc(32'(tgt_idx_i[k]), 32'(NumIn)));
                end
            end
            for (int j = 0; j < int'(NumIn); j++) begin
                if (req_i[j] && !gnt_i[j]) begin
                    if (age_q[j] != AgeW'(StarveThresh)) begin
                        age_q[j] <= age_q[j] + AgeW'(1);
                    end
                end else begin
                    age_q[j] <= '0;
                end
            end
        end
    end

    // Starvation flags come from registered age; boost candidates are still gated by live req/add.
    always_comb begin
        starve_o = '0;
        cand_c   = '0;
        for (int j = 0; j < int'(NumIn); j++) begin
            starve_o[j] = (StarveThresh != 0) && (age_q[j] == AgeW'(StarveThresh));
        end
        for (int k = 0; k < int'(NumOut); k++) begin
            for (int j = 0; j < int'(NumIn); j++) begin
                cand_c[k][j] = starve_o[j] && req_i[j] && (add_i[j] == AddW'(k));
            end
        end
    end

    for (genvar k = 0; k < int'(NumOut); k++) begin : g_pick
        rr_prio_pick #(
            .NumIn (NumIn)
        ) u_pick (
            .cand    (cand_c[k]),
            .ptr     (ptr_q[k]),
            .valid_c (pick_valid[k]),
            .idx_c   (pick_idx[k])
        );

        assign rr_o[k]    = pick_valid[k] ? pick_idx[k] : ptr_q[k];
        assign boost_o[k] = pick_valid[k];
    end

endmodule

// File: tb/tb_xbar_prio_scheduler.sv
// Directed bench for xbar_prio_scheduler: vector table plus hand-written multi-cycle sequences.
// A second instance with StarveThresh=0 shares all inputs to cover the boost-disabled build.
module tb_xbar_prio_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [7:0] add;
    logic [3:0] treq;
    logic [3:0] tgnt;
    logic [7:0] tidx;

    logic [7:0] rr;
    logic [3:0] boost;
    logic [3:0] starve;
    logic [7:0] rr0;
    logic [3:0] boost0;
    logic [3:0] starve0;

    int n_tests = 0;
    int n_fail  = 0;

    xbar_prio_scheduler #(
        .NumIn        (4),
        .NumOut       (4),
        .StarveThresh (3)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .gnt_i     (gnt),
        .add_i     (add),
        .tgt_req_i (treq),
        .tgt_gnt_i (tgnt),
        .tgt_idx_i (tidx),
        .rr_o      (rr),
        .boost_o   (boost),
        .starve_o  (starve)
    );

    xbar_prio_scheduler #(
        .NumIn        (4),
        .NumOut       (4),
        .StarveThresh (0)
    ) dut0 (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .gnt_i     (gnt),
        .add_i     (add),
        .tgt_req_i (treq),
        .tgt_gnt_i (tgnt),
        .tgt_idx_i (tidx),
        .rr_o      (rr0),
        .boost_o   (boost0),
        .starve_o  (starve0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [7:0] add;
        logic [3:0] treq;
        logic [3:0] tgnt;
        logic [7:0] tidx;
        logic       chk;
        logic [7:0] rr;
        logic [3:0] boost;
        logic [3:0] starve;
    } vec_t;

    localparam int NVec = 22;
    vec_t vecs [NVec];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            rst   req   gnt   add    treq  tgnt  tidx   chk   rr     boost starve
        vecs[0]  = '{1'b1, 4'hF, 4'h0, 8'hE4, 4'h0, 4'h0, 8'h00, 1'b0, 8'h00, 4'h0, 4'h0};
        vecs[1]  = '{1'b1, 4'hF, 4'h0, 8'hE4, 4'h0, 4'h0, 8'h00, 1'b1, 8'h00, 4'h0, 4'h0};
        vecs[2]  = '{1'b0, 4'hF, 4'h0, 8'hE4, 4'h0, 4'h0, 8'h00, 1'b1, 8'h00, 4'h0, 4'h0};
        vecs[3]  = '{1'b0, 4'h0, 4'h0, 8'h00, 4'h0, 4'h0, 8'h00, 1'b1, 8'h00, 4'h0, 4'h0};
        // pointer at target 2: idx 1 -> 2, idx 3 wraps to 0, back to 2, then holds
        vecs[4]  = '{1'b0, 4'h0, 4'h0, 8'h00, 4'h4, 4'h4, 8'h10, 1'b1, 8'h00, 4'h0, 4'h0};
        vecs[5]  = '{1'b0, 4'h0, 4'h0, 8'h00, 4'h4, 4'h4, 8'h30, 1'b1, 8'h20, 4'h0, 4'h0};
        vecs[6]  = '{1'b0, 4'h0, 4'h0, 8'h00, 4'h4, 4'h4, 8'h10, 1'b1, 8'h00, 4'h0, 4'h0};
        vecs[7]  = '{1'b0, 4'h0, 4'h0, 8'h00, 4'h0, 4'h0, 8'h00, 1'b1, 8'h20, 4'h0, 4'h0};
        vecs[8]  = '{1'b0, 4'h0, 4'h0, 8'h00, 4'h0, 4'h4, 8'h30, 1'b1, 8'h20, 4'h0, 4'h0};
        // initiator 1 waits on target 0 (address wobble mid-wait), boosts, then is granted
        vecs[9]  = '{1'b0, 4'h2, 4'h0, 8'h00, 4'h0, 4'h0, 8'h00, 1'b1, 8'h20, 4'h0, 4'h0};
        vecs[10] = '{1'b0, 4'h2, 4'h0, 8'h08, 4'h0, 4'h0, 8'h00, 1'b1, 8'h20, 4'h0, 4'h0};
        vecs[11] = '{1'b0, 4'h2, 4'h0, 8'h00, 4'h0, 4'h0, 8'h00, 1'b1, 8'h20, 4'h0, 4'h0};
        vecs[12] = '{1'b0, 4'h2, 4'h2, 8'h00, 4'h1, 4'h1, 8'h01, 1'b1, 8'h21, 4'h1, 4'h2};
        vecs[13] = '{1'b0, 4'h2, 4'h0, 8'h00, 4'h0, 4'h0, 8'h00, 1'b1, 8'h22, 4'h0, 4'h0};
        vecs[14] = '{1'b0, 4'h0, 4'h0, 8'h00, 4'h0, 4'h0, 8'h00, 1'b1, 8'h22, 4'h0, 4'h0};
        // initiators 0 and 2 starve on target 3 with ptr[3] = 1, then 3, then 1 again
        vecs[15] = '{1'b0, 4'h5, 4'h0, 8'h33, 4'h8, 4'h8, 8'h00, 1'b1, 8'h22, 4'h0, 4'h0};
        vecs[16] = '{1'b0, 4'h5, 4'h0, 8'h33, 4'h0, 4'h0, 8'h00, 1'b1, 8'h62, 4'h0, 4'h0};
        vecs[17] = '{1'b0, 4'h5, 4'h0, 8'h33, 4'h0, 4'h0, 8'h00, 1'b1, 8'h62, 4'h0, 4'h0};
        vecs[18] = '{1'b0, 4'h5, 4'h0, 8'h33, 4'h8, 4'h8, 8'h80, 1'b1, 8'hA2, 4'h8, 4'h5};
        vecs[19] = '{1'b0, 4'h5, 4'h0, 8'h33, 4'h8, 4'h8, 8'h00, 1'b1, 8'h22, 4'h8, 4'h5};
        vecs[20] = '{1'b0, 4'h1, 4'h0, 8'h33, 4'h0, 4'h0, 8'h00, 1'b1, 8'h22, 4'h8, 4'h5};
        vecs[21] = '{1'b0, 4'h0, 4'h0, 8'h33, 4'h0, 4'h0, 8'h00, 1'b1, 8'h62, 4'h0, 4'h1};

        {rst, req, gnt, add, treq, tgnt, tidx} = '0;
        #1;

        for (int i = 0; i < NVec; i++) begin
            rst  = vecs[i].rst;
            req  = vecs[i].req;
            gnt  = vecs[i].gnt;
            add  = vecs[i].add;
            treq = vecs[i].treq;
            tgnt = vecs[i].tgnt;
            tidx = vecs[i].tidx;
            #1;
            if (vecs[i].chk) begin
                check($sformatf("v%0d rr_o", i), 32'(rr), 32'(vecs[i].rr));
                check($sformatf("v%0d boost_o", i), 32'(boost), 32'(vecs[i].boost));
                check($sformatf("v%0d starve_o", i), 32'(starve), 32'(vecs[i].starve));
            end
            next_cycle();
        end

        // Boost disabled: everyone waits on target 1, nothing starves, rr_o stays the pointers.
        rst  = 1'b0;
        req  = 4'hF;
        gnt  = 4'h0;
        add  = 8'h55;
        treq = 4'h0;
        tgnt = 4'h0;
        tidx = 8'h00;
        for (int c = 0; c < 20; c++) begin
            #1;
            check($sformatf("off c%0d starve_o", c), 32'(starve0), 32'h0);
            check($sformatf("off c%0d boost_o", c), 32'(boost0), 32'h0);
            check($sformatf("off c%0d rr_o", c), 32'(rr0), 32'h62);
            next_cycle();
        end

        // Main instance is now fully starved on target 1, with ptr[0] = 2.
        #1;
        check("pre-rst starve_o", 32'(starve), 32'hF);
        check("pre-rst boost_o", 32'(boost), 32'h2);
        check("pre-rst rr_o", 32'(rr), 32'h62);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        check("post-rst rr_o", 32'(rr), 32'h00);
        check("post-rst boost_o", 32'(boost), 32'h0);
        check("post-rst starve_o", 32'(starve), 32'h0);
        check("post-rst off rr_o", 32'(rr0), 32'h00);
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            check($sformatf("re-starve c%0d starve_o", c), 32'(starve),
                  (c == 3) ? 32'hF : 32'h0);
            check($sformatf("re-starve c%0d boost_o", c), 32'(boost),
                  (c == 3) ? 32'h2 : 32'h0);
            check($sformatf("re-starve c%0d rr_o", c), 32'(rr), 32'h00);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
